dec24_scan: RTL and testbench

- Registered 2-to-4 one-hot decoder with enable; the decode-side counterpart of the board-level 4-to-2 encoder in the digit test.
- Two modes:
  - Direct: decodes a handshaked 2-bit code.
  - Scan: walks codes 0..3 automatically at a divided rate, to drive digit-select or LED strobes.
- Sits between switch/encoder logic and NVBoard LED / 7-seg select pins.

---
 rtl/dec24_pkg.sv | 20 ++
 rtl/scan_prescaler.sv | 40 ++++
 rtl/dec24_scan.sv | 117 +++++++++++
 tb/tb_dec24_scan.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dec24_pkg.sv
// Shared types and helpers for the 2-to-4 scan/direct decoder.
package dec24_pkg;

    localparam int unsigned OUT_W = 4;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDirect = 2'd1,
        StScan   = 2'd2
    } dec24_state_e;

    // Two-bit code to one-hot select.
    function automatic logic [OUT_W-1:0] onehot4(input logic [1:0] code);
        logic [OUT_W-1:0] res;
        res       = '0;
        res[code] = 1'b1;
        return res;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Divides the clock into one tick every SCAN_DIV cycles while running.
module scan_prescaler #(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic run_i,
    output logic tick_o
);

    localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(SCAN_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            last;

    assign last   = (cnt_q == CntLast);
    assign tick_o = run_i & ~clear_i & last;

    // Next count: clear wins, otherwise count 0..SCAN_DIV-1 while running.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = last ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dec24_scan.sv
// Registered 2-to-4 one-hot decoder with direct (handshaked) and auto-scan modes.
module dec24_scan
    import dec24_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 4,
    parameter bit          OUT_INV  = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             mode_i,
    input  logic             in_valid_i,
    input  logic [1:0]       in_i,
    output logic             in_ready_o,
    output logic [OUT_W-1:0] out_o,
    output logic             out_valid_o,
    output logic [1:0]       code_o,
    output logic             scan_wrap_o
);

    dec24_state_e     state_q;
    logic [OUT_W-1:0] out_q;
    logic             valid_q;
    logic [1:0]       code_q;
    logic             wrap_q;

    logic             presc_clear;
    logic             presc_run;
    logic             tick;

    // Prescaler sits at zero outside SCAN so every scan entry starts fresh.
    assign presc_clear = (state_q != StScan);
    assign presc_run   = (state_q == StScan) & en_i & mode_i;

    scan_prescaler #(
        .SCAN_DIV (SCAN_DIV)
    ) u_prescaler (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (presc_clear),
        .run_i   (presc_run),
        .tick_o  (tick)
    );

    // Mode FSM with registered decode outputs; any mode change passes through IDLE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            out_q   <= '0;
            valid_q <= 1'b0;
            code_q  <= 2'd0;
            wrap_q  <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            if (!en_i) begin
                // Any handshake in this cycle is deliberately dropped.
                state_q <= StIdle;
                out_q   <= '0;
                valid_q <= 1'b0;
                code_q  <= 2'd0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (mode_i) begin
                            state_q <= StScan;
                            out_q   <= onehot4(2'd0);
                            valid_q <= 1'b1;
                            code_q  <= 2'd0;
                        end else begin
                            state_q <= StDirect;
                            out_q   <= '0;
                            valid_q <= 1'b0;
                            code_q  <= 2'd0;
                        end
                    end
                    StDirect: begin
                        if (mode_i) begin
                            state_q <= StIdle;
                            out_q   <= '0;
                            valid_q <= 1'b0;
                            code_q  <= 2'd0;
                        end else if (in_valid_i) begin
                            out_q   <= onehot4(in_i);
                            valid_q <= 1'b1;
                            code_q  <= in_i;
                        end
                    end
                    StScan: begin
                        if (!mode_i) begin
                            state_q <= StIdle;
                            out_q   <= '0;
                            valid_q <= 1'b0;
                            code_q  <= 2'd0;
                        end else if (tick) begin
                            code_q <= code_q + 2'd1;
                            out_q  <= onehot4(code_q + 2'd1);
                            wrap_q <= (code_q == 2'd3);
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        out_q   <= '0;
                        valid_q <= 1'b0;
                        code_q  <= 2'd0;
                    end
                endcase
            end
        end
    end

    assign in_ready_o  = (state_q == StDirect);
    assign out_o       = OUT_INV ? ~out_q : out_q;
    assign out_valid_o = valid_q;
    assign code_o      = code_q;
    assign scan_wrap_o = wrap_q;

endmodule

// File: tb/tb_dec24_scan.sv
// Scoreboard bench for dec24_scan: behavioural model for a SCAN_DIV=3 instance,
// directed checks on an inverted SCAN_DIV=1 instance including async reset.
module tb_dec24_scan;

    localparam int unsigned Div1 = 3;

    typedef struct packed {
        logic [3:0] out;
        logic       valid;
        logic [1:0] code;
        logic       ready;
        logic       wrap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n, en, mode, in_valid;
    logic [1:0] in_code;
    logic       in_ready, out_valid, scan_wrap;
    logic [3:0] out;
    logic [1:0] code;

    logic       rst2_n, en2, mode2, in_valid2;
    logic [1:0] in_code2;
    logic       in_ready2, out_valid2, scan_wrap2;
    logic [3:0] out2;
    logic [1:0] code2;

    int n_vec = 0;
    int n_err = 0;

    exp_t sb_q[$];

    // Reference model state: n counts scan cycles since entry.
    int         m_state;
    int         m_n;
    logic [1:0] m_code;
    logic       m_valid;
    logic       m_wrap;

    always #5 clk = ~clk;

    dec24_scan #(
        .SCAN_DIV (Div1),
        .OUT_INV  (1'b0)
    ) u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .en_i        (en),
        .mode_i      (mode),
        .in_valid_i  (in_valid),
        .in_i        (in_code),
        .in_ready_o  (in_ready),
        .out_o       (out),
        .out_valid_o (out_valid),
        .code_o      (code),
        .scan_wrap_o (scan_wrap)
    );

    dec24_scan #(
        .SCAN_DIV (1),
        .OUT_INV  (1'b1)
    ) u_dut_inv (
        .clk_i       (clk),
        .rst_ni      (rst2_n),
        .en_i        (en2),
        .mode_i      (mode2),
        .in_valid_i  (in_valid2),
        .in_i        (in_code2),
        .in_ready_o  (in_ready2),
        .out_o       (out2),
        .out_valid_o (out_valid2),
        .code_o      (code2),
        .scan_wrap_o (scan_wrap2)
    );

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.valid = m_valid;
        e.code  = m_code;
        e.out   = m_valid ? (4'b0001 << m_code) : 4'b0000;
        e.ready = (m_state == 1);
        e.wrap  = m_wrap;
        return e;
    endfunction

    // Advance the model by one clock edge under the given inputs.
    task automatic model_step(input logic e, input logic m, input logic v, input logic [1:0] c);
        m_wrap = 1'b0;
        if (!e) begin
            m_state = 0;
            m_valid = 1'b0;
        end else begin
            case (m_state)
                0: begin
                    if (m) begin
                        m_state = 2;
                        m_n     = 0;
                        m_code  = 2'd0;
                        m_valid = 1'b1;
                    end else begin
                        m_state = 1;
                        m_valid = 1'b0;
                    end
                end
                1: begin
                    if (m) begin
                        m_state = 0;
                        m_valid = 1'b0;
                    end else if (v) begin
                        m_code  = c;
                        m_valid = 1'b1;
                    end
                end
                default: begin
                    if (!m) begin
                        m_state = 0;
                        m_valid = 1'b0;
                    end else begin
                        m_n++;
                        m_code = 2'((m_n / Div1) % 4);
                        m_wrap = ((m_n % Div1) == 0) && (m_code == 2'd0);
                    end
                end
            endcase
        end
        sb_q.push_back(model_out());
    endtask

    task automatic sb_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 8'd1, 8'd0);
        end else begin
            e = sb_q.pop_front();
            check_val("sb_out", {4'h0, out}, {4'h0, e.out});
            check_val("sb_valid", {7'h0, out_valid}, {7'h0, e.valid});
            check_val("sb_ready", {7'h0, in_ready}, {7'h0, e.ready});
            check_val("sb_wrap", {7'h0, scan_wrap}, {7'h0, e.wrap});
            if (e.valid) check_val("sb_code", {6'h0, code}, {6'h0, e.code});
        end
    endtask

    // At the falling edge: compare the current cycle, then apply the next inputs.
    task automatic drive(input logic e, input logic m, input logic v, input logic [1:0] c);
        @(negedge clk);
        sb_check();
        en       = e;
        mode     = m;
        in_valid = v;
        in_code  = c;
        model_step(e, m, v, c);
    endtask

    initial begin
        logic       r_en, r_mode, r_v;
        logic [1:0] r_c;
        logic [3:0] exp_inv;

        rst_n    = 1'b0;
        en       = 1'b0;
        mode     = 1'b0;
        in_valid = 1'b0;
        in_code  = 2'd0;
        rst2_n   = 1'b0;
        en2      = 1'b1;
        mode2    = 1'b1;
        in_valid2 = 1'b0;
        in_code2 = 2'd0;

        m_state = 0;
        m_n     = 0;
        m_code  = 2'd0;
        m_valid = 1'b0;
        m_wrap  = 1'b0;
        sb_q.push_back(model_out());

        #1;
        check_val("rst_out", {4'h0, out}, 8'h00);
        check_val("rst_code", {6'h0, code}, 8'h00);
        check_val("rst_ready", {7'h0, in_ready}, 8'h00);
        #2 rst_n = 1'b1;

        // Direct mode, single capture of code 2, then hold.
        drive(1'b0, 1'b0, 1'b0, 2'd0);
        drive(1'b1, 1'b0, 1'b0, 2'd0);
        drive(1'b1, 1'b0, 1'b1, 2'd2);
        drive(1'b1, 1'b0, 1'b0, 2'd0);
        check_val("tp_dir_out", {4'h0, out}, 8'h04);
        check_val("tp_dir_code", {6'h0, code}, 8'h02);
        repeat (3) drive(1'b1, 1'b0, 1'b0, 2'd1);

        // Back-to-back handshakes sweeping every code.
        for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, 1'b1, 2'(k));
        drive(1'b1, 1'b0, 1'b0, 2'd0);
        check_val("tp_sweep_last", {4'h0, out}, 8'h08);

        // Full scan cycle with in_valid noise that must be ignored.
        for (int k = 0; k < 18; k++) drive(1'b1, 1'b1, 1'(k % 2), 2'(k));

        // Leave scan, re-enter, and switch to direct while code = 2.
        drive(1'b1, 1'b0, 1'b0, 2'd0);
        drive(1'b1, 1'b0, 1'b0, 2'd0);
        drive(1'b1, 1'b1, 1'b0, 2'd0);
        repeat (8) drive(1'b1, 1'b1, 1'b0, 2'd0);
        drive(1'b1, 1'b0, 1'b0, 2'd0);
        check_val("tp_mid_code", {6'h0, code}, 8'h02);
        drive(1'b1, 1'b0, 1'b0, 2'd0);
        check_val("tp_mid_idle", {3'h0, out_valid, out}, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 2'd0);
        drive(1'b1, 1'b0, 1'b1, 2'd1);
        drive(1'b1, 1'b1, 1'b0, 2'd0);
        repeat (4) drive(1'b1, 1'b1, 1'b0, 2'd0);

        // en drop with a simultaneous handshake: capture is discarded.
        drive(1'b1, 1'b0, 1'b0, 2'd0);
        drive(1'b1, 1'b0, 1'b0, 2'd0);
        drive(1'b1, 1'b0, 1'b1, 2'd1);
        drive(1'b0, 1'b0, 1'b1, 2'd3);
        drive(1'b0, 1'b0, 1'b0, 2'd0);
        check_val("tp_endrop", {3'h0, out_valid, out}, 8'h00);
        repeat (3) drive(1'b1, 1'b0, 1'b0, 2'd3);
        drive(1'b1, 1'b0, 1'b1, 2'd3);

        // en rise together with mode = 1 and stale in_valid enters scan.
        drive(1'b0, 1'b0, 1'b0, 2'd0);
        drive(1'b1, 1'b1, 1'b1, 2'd2);
        repeat (3) drive(1'b1, 1'b1, 1'b1, 2'd2);

        // Random traffic against the model.
        r_mode = 1'b0;
        for (int k = 0; k < 150; k++) begin
            r_en   = ($urandom_range(0, 11) != 0);
            r_mode = ($urandom_range(0, 9) == 0) ? ~r_mode : r_mode;
            r_v    = 1'($urandom_range(0, 1));
            r_c    = 2'($urandom_range(0, 3));
            drive(r_en, r_mode, r_v, r_c);
        end
        @(negedge clk);
        sb_check();
        en = 1'b0;

        // Inverted, SCAN_DIV = 1 instance: reset values, stepping, async reset.
        check_val("inv_rst_out", {4'h0, out2}, 8'h0f);
        rst2_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            exp_inv = ~(4'b0001 << (k % 4));
            check_val("inv_scan_out", {4'h0, out2}, {4'h0, exp_inv});
            check_val("inv_scan_wrap", {7'h0, scan_wrap2}, {7'h0, (k == 4)});
            check_val("inv_scan_ready", {7'h0, in_ready2}, 8'h00);
        end
        #2 rst2_n = 1'b0;
        #1;
        check_val("inv_async_out", {4'h0, out2}, 8'h0f);
        check_val("inv_async_valid", {7'h0, out_valid2}, 8'h00);
        check_val("inv_async_code", {6'h0, code2}, 8'h00);
        @(negedge clk);
        rst2_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            exp_inv = ~(4'b0001 << (k % 4));
            check_val("inv_rescan_out", {4'h0, out2}, {4'h0, exp_inv});
            check_val("inv_rescan_wrap", {7'h0, scan_wrap2}, {7'h0, (k == 4)});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
